noc_input_port_ctrl: RTL

//  Router input-port stage directly downstream of the input fifo. Drains the fifo
//  (registered read, data 1 cycle after rd_en), checks packet framing, computes the XY

---
 rtl/noc_input_port_ctrl_if.sv | 25 ++
 rtl/noc_input_port_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/noc_input_port_ctrl_if.sv
// Handshake bundle between the router input fifo, the input-port controller
// and the crossbar/arbiter. The master side is the input-port controller.
interface noc_input_port_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_empty_i;
  logic                  fifo_rd_en_o;
  logic [DATA_WIDTH-1:0] flit_o;
  logic [4:0]            route_o;
  logic                  flit_valid_o;
  logic                  flit_ready_i;
  logic                  err_o;
  logic [7:0]            drop_cnt_o;

  modport master (
    input  fifo_data_i, fifo_empty_i, flit_ready_i,
    output fifo_rd_en_o, flit_o, route_o, flit_valid_o, err_o, drop_cnt_o
  );

  modport slave (
    output fifo_data_i, fifo_empty_i, flit_ready_i,
    input  fifo_rd_en_o, flit_o, route_o, flit_valid_o, err_o, drop_cnt_o
  );
endinterface

// File: rtl/noc_input_port_ctrl.sv
// Router input-port controller: drains the input fifo (registered read),
// checks packet framing, computes the XY route of head/single flits and
// presents {flit, route} through a 2-entry buffer on a valid/ready handshake.
// Pipeline: p0 = read issue, p1 = fifo data capture, p2 = output buffer.
module noc_input_port_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int COORD_W    = 2,
  parameter int X_CORD     = 0,
  parameter int Y_CORD     = 0,
  parameter int ID         = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  noc_input_port_ctrl_if.master bus
);

  localparam logic [1:0] TYPE_SINGLE = 2'b00;
  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_BODY   = 2'b10;
  localparam logic [1:0] TYPE_TAIL   = 2'b11;

  localparam logic [4:0] ROUTE_E = 5'b00001;
  localparam logic [4:0] ROUTE_W = 5'b00010;
  localparam logic [4:0] ROUTE_N = 5'b00100;
  localparam logic [4:0] ROUTE_S = 5'b01000;
  localparam logic [4:0] ROUTE_L = 5'b10000;

  localparam logic [COORD_W-1:0] X_POS = COORD_W'(X_CORD);
  localparam logic [COORD_W-1:0] Y_POS = COORD_W'(Y_CORD);

  // ID only tags the instance for debug; a negative id would be a wiring bug
  // upstream, so it also qualifies the read enable.
  localparam logic ID_OK = (ID >= 0);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;

  // Dimension-ordered routing: resolve X first, then Y, else eject locally.
  function automatic logic [4:0] xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    if (dx > X_POS)      return ROUTE_E;
    else if (dx < X_POS) return ROUTE_W;
    else if (dy > Y_POS) return ROUTE_N;
    else if (dy < Y_POS) return ROUTE_S;
    else                 return ROUTE_L;
  endfunction

  state_e                state_q, state_d;
  logic                  vld_p1;
  logic [1:0]            occ_q;
  logic [DATA_WIDTH-1:0] flit_p2 [2];
  logic [4:0]            route_p2 [2];
  logic [4:0]            cur_route_q;
  logic                  err_q;
  logic [7:0]            drop_cnt_q;

  logic                  pop;
  logic [2:0]            room_p0;
  logic                  rd_en_p0;
  logic [1:0]            ftype_p1;
  logic [4:0]            new_route_p1;
  logic                  push, err_d, drop, latch_route;
  logic [4:0]            push_route;

  assign pop      = (occ_q != 2'd0) && bus.flit_ready_i;
  assign room_p0  = {1'b0, occ_q} + {2'b00, vld_p1} - {2'b00, pop};
  assign rd_en_p0 = rst_ni && ID_OK && !bus.fifo_empty_i && (room_p0 < 3'd2);

  assign ftype_p1     = bus.fifo_data_i[DATA_WIDTH-1 -: 2];
  assign new_route_p1 = xy_route(bus.fifo_data_i[DATA_WIDTH-3 -: COORD_W],
                                 bus.fifo_data_i[DATA_WIDTH-3-COORD_W -: COORD_W]);

  // Framing FSM state register, advanced only on a captured flit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: a head opens a packet, tail/single close it.
  always_comb begin
    state_d = state_q;
    if (vld_p1) begin
      case (state_q)
        IDLE: if (ftype_p1 == TYPE_HEAD) state_d = PKT;
        PKT:  if (ftype_p1 == TYPE_TAIL || ftype_p1 == TYPE_SINGLE) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Capture actions: accept/drop, error flag and route selection per flit.
  always_comb begin
    push        = 1'b0;
    err_d       = 1'b0;
    drop        = 1'b0;
    latch_route = 1'b0;
    push_route  = cur_route_q;
    if (vld_p1) begin
      case (state_q)
        IDLE: begin
          case (ftype_p1)
            TYPE_HEAD: begin
              push = 1'b1; latch_route = 1'b1; push_route = new_route_p1;
            end
            TYPE_SINGLE: begin
              push = 1'b1; push_route = new_route_p1;
            end
            default: begin
              drop = 1'b1; err_d = 1'b1;
            end
          endcase
        end
        PKT: begin
          case (ftype_p1)
            TYPE_HEAD: begin
              // previous packet never saw its tail; restart on the new head
              push = 1'b1; err_d = 1'b1; latch_route = 1'b1; push_route = new_route_p1;
            end
            TYPE_SINGLE: begin
              push = 1'b1; err_d = 1'b1; push_route = new_route_p1;
            end
            default: push = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Read-in-flight flag, latched packet route, error pulse and drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1      <= 1'b0;
      cur_route_q <= '0;
      err_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      vld_p1 <= rd_en_p0;
      err_q  <= err_d;
      if (latch_route) cur_route_q <= new_route_p1;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // Two-entry output buffer, slot 0 is the head; push and pop may coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q       <= '0;
      flit_p2[0]  <= '0;
      flit_p2[1]  <= '0;
      route_p2[0] <= '0;
      route_p2[1] <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            flit_p2[0]  <= bus.fifo_data_i;
            route_p2[0] <= push_route;
          end else begin
            flit_p2[1]  <= bus.fifo_data_i;
            route_p2[1] <= push_route;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          flit_p2[0]  <= flit_p2[1];
          route_p2[0] <= route_p2[1];
          occ_q       <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            flit_p2[0]  <= bus.fifo_data_i;
            route_p2[0] <= push_route;
          end else begin
            flit_p2[0]  <= flit_p2[1];
            route_p2[0] <= route_p2[1];
            flit_p2[1]  <= bus.fifo_data_i;
            route_p2[1] <= push_route;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_en_o = rd_en_p0;
  assign bus.flit_o       = flit_p2[0];
  assign bus.route_o      = route_p2[0];
  assign bus.flit_valid_o = (occ_q != 2'd0);
  assign bus.err_o        = err_q;
  assign bus.drop_cnt_o   = drop_cnt_q;

endmodule
